// File: rtl/pixel_pack_fifo_if.sv
// Pixel packer FIFO bus: SDRAM halfword write side, pixel read side and status.
// The master drives the stream and pops; the slave (the FIFO) reports its state.
interface pixel_pack_fifo_if #(
  parameter int DEPTH = 64
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             we;
  logic [15:0]      din;
  logic             pop_front;
  logic [23:0]      dout;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             buf_lw;
  logic             buf_hw;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, we, din, pop_front,
    input  dout, empty, full, level, buf_lw, buf_hw, overflow, underflow
  );

  modport slave (
    input  flush, we, din, pop_front,
    output dout, empty, full, level, buf_lw, buf_hw, overflow, underflow
  );
endinterface

// File: rtl/pixel_pack_fifo.sv
// Packs the 16-bit SDRAM read stream into 24-bit RGB pixels (3 halfwords -> 2 pixels)
// and buffers them in a first-word-fall-through FIFO with low/high watermarks.
module pixel_pack_fifo #(
  parameter int DEPTH   = 64,
  parameter int LW_MARK = 16,
  parameter int HW_MARK = 48
) (
  input logic              clk143,
  input logic              reset_n,
  pixel_pack_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [1:0] PK0 = 2'd0;
  localparam logic [1:0] PK1 = 2'd1;
  localparam logic [1:0] PK2 = 2'd2;

  logic [1:0]       packState_q, packState_d;
  logic [15:0]      stash_q, stash_d;
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, underflow_q;
  logic [23:0]      mem [DEPTH];

  logic             pushValid;
  logic [23:0]      pushData;
  logic             isEmpty, isFull;
  logic             doPush, doPop;

  assign isEmpty = (level_q == '0);
  assign isFull  = (level_q == LVL_W'(DEPTH));

  // A pop only happens when there is something to pop; a push into a full FIFO
  // still lands if the same edge frees a slot through a pop.
  assign doPop  = bus.pop_front && !isEmpty;
  assign doPush = pushValid && (!isFull || doPop);

  // Packer: the first halfword of a triple is stashed, the next two each complete a pixel.
  always_comb begin
    packState_d = packState_q;
    stash_d     = stash_q;
    pushValid   = 1'b0;
    pushData    = '0;
    if (bus.we) begin
      case (packState_q)
        PK0: begin
          stash_d     = bus.din;
          packState_d = PK1;
        end
        PK1: begin
          pushValid   = 1'b1;
          pushData    = {stash_q, bus.din[15:8]};
          stash_d     = {stash_q[15:8], bus.din[7:0]};
          packState_d = PK2;
        end
        PK2: begin
          pushValid   = 1'b1;
          pushData    = {stash_q[7:0], bus.din};
          packState_d = PK0;
        end
        default: begin
          packState_d = PK0;
        end
      endcase
    end
  end

  // Occupancy counter: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk143 or negedge reset_n) begin
    if (!reset_n) begin
      packState_q <= PK0;
      stash_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      packState_q <= PK0;
      stash_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      packState_q <= packState_d;
      stash_q     <= stash_d;
      level_q     <= level_d;
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      if (pushValid && !doPush) begin
        overflow_q <= 1'b1;
      end
      if (bus.pop_front && isEmpty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Pixel storage; contents are not reset and only matter between the pointers.
  always_ff @(posedge clk143) begin
    if (doPush && !bus.flush) begin
      mem[wrPtr_q] <= pushData;
    end
  end

  // The head is shown with no added latency; it reads as zero while the FIFO is empty.
  assign bus.dout      = isEmpty ? 24'h0 : mem[rdPtr_q];
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;
  assign bus.level     = level_q;
  assign bus.buf_lw    = (level_q <= LVL_W'(LW_MARK));
  assign bus.buf_hw    = (level_q >= LVL_W'(HW_MARK));
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule
